// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - byte FIFO that feeds a UART one launch pulse at a time
module uart_tx_queue #(
    parameter int DEPTH         = 16,
    parameter int START_TIMEOUT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [7:0]              wr_data,
    input  logic                    clr_ovf,
    input  logic                    is_transmitting,
    output logic [7:0]              tx_byte,
    output logic                    transmit,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_START,
        WAIT_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [TW-1:0]   tcnt;
    logic            pop;
    logic            push_ok;
    logic            drop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign busy  = (state != IDLE);

    // A pop frees a slot in the same edge, so a full queue still accepts a coincident push.
    assign push_ok = wr_en && (!full || pop);
    assign drop    = wr_en && full && !pop;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !is_transmitting) begin
                    pop       = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: state_nxt = WAIT_START;
            WAIT_START: begin
                if (is_transmitting) begin
                    state_nxt = WAIT_DONE;
                end else if (tcnt == TW'(START_TIMEOUT - 1)) begin
                    // UART never acknowledged; the byte is treated as sent.
                    state_nxt = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!is_transmitting) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            transmit <= 1'b0;
            tx_byte  <= 8'h00;
            tcnt     <= '0;
        end else begin
            state    <= state_nxt;
            transmit <= pop;
            if (pop) begin
                tx_byte <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
            if (state == LAUNCH) begin
                tcnt <= '0;
            end else if (state == WAIT_START && !is_transmitting) begin
                tcnt <= tcnt + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb/tb_uart_tx_queue.sv - directed and random checks of uart_tx_queue against a queue model
module tb_uart_tx_queue;

    localparam int DEPTH         = 16;
    localparam int START_TIMEOUT = 4;
    localparam int CW            = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          clr_ovf;
    logic          is_transmitting = 1'b0;
    logic [7:0]    tx_byte;
    logic          transmit;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          busy;

    uart_tx_queue #(.DEPTH(DEPTH), .START_TIMEOUT(START_TIMEOUT)) dut (
        .clk             (clk),
        .rst             (rst),
        .wr_en           (wr_en),
        .wr_data         (wr_data),
        .clr_ovf         (clr_ovf),
        .is_transmitting (is_transmitting),
        .tx_byte         (tx_byte),
        .transmit        (transmit),
        .full            (full),
        .empty           (empty),
        .count           (count),
        .overflow        (overflow),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];
    logic       ovf_m = 1'b0;
    int         tx_cyc[$];
    int         tx_total = 0;
    int         push_cyc = 0;
    logic [7:0] last_tx = 8'h00;
    int         uart_mode = 0;
    int         busy_len = 3;
    int         ucnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference model: the queue holds exactly the accepted bytes; a pop is visible as a transmit pulse.
    initial begin
        logic       r, w, c, full_b;
        logic [7:0] d;
        forever begin
            @(posedge clk);
            r = rst; w = wr_en; d = wr_data; c = clr_ovf;
            cyc++;
            #1;
            if (r) begin
                exp_q.delete();
                ovf_m = 1'b0;
                check("rst_transmit", transmit, 0);
                check("rst_tx_byte", tx_byte, 0);
            end else begin
                full_b = (exp_q.size() == DEPTH);
                if (transmit) begin
                    tx_total++;
                    tx_cyc.push_back(cyc);
                    last_tx = tx_byte;
                    check("tx_when_queued", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        check("tx_byte_order", tx_byte, exp_q[0]);
                        void'(exp_q.pop_front());
                    end
                end
                if (w && (!full_b || transmit)) begin
                    exp_q.push_back(d);
                    push_cyc = cyc;
                end
                if (w && full_b && !transmit) ovf_m = 1'b1;
                else if (c) ovf_m = 1'b0;
            end
            check("count", count, exp_q.size());
            check("full", full, exp_q.size() == DEPTH);
            check("empty", empty, exp_q.size() == 0);
            check("overflow", overflow, ovf_m);
            case (uart_mode)
                0: begin
                    if (transmit) ucnt = busy_len;
                    else if (ucnt > 0) ucnt--;
                    is_transmitting = (ucnt > 0);
                end
                1: begin ucnt = 0; is_transmitting = 1'b0; end
                default: begin ucnt = 0; is_transmitting = 1'b1; end
            endcase
        end
    end

    task automatic push(input logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain(input string tag, input int max);
        int k = 0;
        while (!(empty && !busy) && k < max) begin
            @(negedge clk);
            k++;
        end
        check(tag, k < max, 1);
    endtask

    initial begin
        int n0;
        int k;
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clr_ovf = 1'b0;
        idle(2);
        check("reset_count", count, 0);
        check("reset_empty", empty, 1);
        check("reset_full", full, 0);
        check("reset_overflow", overflow, 0);
        check("reset_busy", busy, 0);
        check("reset_transmit", transmit, 0);
        rst = 1'b0;
        idle(2);

        // Single byte, UART busy for 10 cycles
        uart_mode = 0; busy_len = 10;
        n0 = tx_total;
        push(8'h41);
        wait_drain("single_drain", 200);
        check("single_pulses", tx_total - n0, 1);
        check("single_latency_edges", tx_cyc[tx_cyc.size()-1] - push_cyc, 1);
        check("single_byte", last_tx, 8'h41);
        check("single_busy", busy, 0);

        // Ordered bytes spaced across drains, pointers wrap
        busy_len = 2;
        n0 = tx_total;
        for (int i = 0; i < 20; i++) begin
            push(8'(i));
            idle($urandom_range(0, 3));
        end
        wait_drain("order_drain", 2000);
        check("order_pulses", tx_total - n0, 20);
        check("order_last", last_tx, 8'h13);
        check("order_overflow", overflow, 0);

        // Overflow with UART held busy
        busy_len = 1000;
        n0 = tx_total;
        for (int i = 0; i < DEPTH + 1; i++) push(8'h80 + 8'(i));
        check("ovf_full", full, 1);
        check("ovf_count", count, DEPTH);
        check("ovf_not_yet", overflow, 0);
        push(8'hEE);
        check("ovf_set", overflow, 1);
        check("ovf_count_after_drop", count, DEPTH);
        check("ovf_one_launch", tx_total - n0, 1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("ovf_cleared", overflow, 0);

        // Full queue, push coincides with a pop
        uart_mode = 1;
        k = 0;
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("release_idle", busy, 0);
        push(8'hA5);
        check("fullpop_count", count, DEPTH);
        check("fullpop_full", full, 1);
        check("fullpop_overflow", overflow, 0);
        uart_mode = 0; busy_len = 3;
        wait_drain("fullpop_drain", 3000);
        check("fullpop_pulses", tx_total - n0, DEPTH + 2);
        check("fullpop_last", last_tx, 8'hA5);
        check("fullpop_model_empty", exp_q.size(), 0);

        // Start timeout with is_transmitting stuck low
        uart_mode = 1;
        n0 = tx_cyc.size();
        push(8'h51);
        push(8'h52);
        wait_drain("timeout_drain", 200);
        check("timeout_pulses", tx_cyc.size() - n0, 2);
        if (tx_cyc.size() - n0 >= 2)
            check("timeout_spacing", tx_cyc[n0+1] - tx_cyc[n0], START_TIMEOUT + 2);

        // Reset mid-drain
        uart_mode = 0; busy_len = 1000;
        for (int i = 0; i < 6; i++) push(8'h60 + 8'(i));
        idle(3);
        check("middrain_busy", busy, 1);
        check("middrain_count", count, 5);
        n0 = tx_total;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_count", count, 0);
        check("rst_mid_empty", empty, 1);
        check("rst_mid_busy", busy, 0);
        uart_mode = 1;
        idle(20);
        check("rst_mid_no_pulses", tx_total - n0, 0);

        // Random traffic with drops and clears
        uart_mode = 0;
        for (int i = 0; i < 200; i++) begin
            busy_len = $urandom_range(0, 4);
            if ($urandom_range(0, 2) != 0) begin
                push(8'($urandom));
            end else begin
                clr_ovf = ($urandom_range(0, 3) == 0);
                @(negedge clk);
                clr_ovf = 1'b0;
            end
        end
        busy_len = 1;
        wait_drain("random_drain", 5000);
        check("random_model_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
